// File: rtl/muxn_rr.sv
// N-channel packet multiplexer with one registered output slot.
// A packet holds its channel until in_last; the grant comes from sel (MODE=0) or a round-robin pointer (MODE=1).
module muxn_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 1,
    localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [SW-1:0]    out_ch,
    input  logic             out_ready
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_LOCKED = 1'b1;
    localparam logic [SW:0]   N_L       = N[SW:0];
    localparam logic [SW-1:0] LAST_CH   = SW'(N - 1);

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;

    logic          load_en;
    logic          gnt_vld;
    logic [SW-1:0] gnt_ch;
    logic          xfer;
    logic [W-1:0]  gnt_data;
    logic          gnt_last;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin : grant_logic
        int unsigned idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        if (state_q == ST_LOCKED) begin
            gnt_ch  = lock_ch_q;
            gnt_vld = in_valid[lock_ch_q];
        end else if (MODE == 0) begin
            gnt_ch  = sel;
            gnt_vld = ({1'b0, sel} < N_L) && in_valid[sel];
        end else begin
            // Scan from farthest to nearest so the channel right after ptr wins.
            for (int unsigned i = N; i >= 1; i--) begin
                idx = 32'(ptr_q) + i;
                if (idx >= 32'(N)) begin
                    idx = idx - 32'(N);
                end
                if (in_valid[idx[SW-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = idx[SW-1:0];
                end
            end
        end
    end

    assign xfer = gnt_vld && load_en && !rst;

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        in_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (gnt_ch == SW'(k)) begin
                gnt_data    = in_data[k*W +: W];
                gnt_last    = in_last[k];
                in_ready[k] = xfer;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_last_d  = gnt_last;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_ch;
            if (gnt_last) begin
                state_d = ST_IDLE;
                if (MODE != 0) begin
                    ptr_d = gnt_ch;
                end
            end else begin
                state_d   = ST_LOCKED;
                lock_ch_d = gnt_ch;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            ptr_q       <= LAST_CH;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Bench for muxn_rr: a round-robin instance and a sel-driven instance share stimulus.
// Vector tables give expected in_ready; accepted beats are queued and matched against out_*.
module tb_muxn_rr;

    typedef struct {
        logic        m;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] data;
        logic [1:0]  sel;
        logic        ordy;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  r_in_ready, s_in_ready;
    logic [7:0]  r_out_data, s_out_data;
    logic        r_out_valid, s_out_valid;
    logic        r_out_last, s_out_last;
    logic [1:0]  r_out_ch, s_out_ch;

    int    checks   = 0;
    int    failures = 0;
    bit    at_neg   = 1'b0;
    vec_t  vecs[$];
    beat_t sb[$];

    always #5 clk = ~clk;

    muxn_rr #(.N(4), .W(8), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(r_in_ready), .sel(sel),
        .out_data(r_out_data), .out_valid(r_out_valid), .out_last(r_out_last),
        .out_ch(r_out_ch), .out_ready(out_ready)
    );

    muxn_rr #(.N(4), .W(8), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(s_in_ready), .sel(sel),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_last(s_out_last),
        .out_ch(s_out_ch), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [3:0] vld, input logic [3:0] lst,
                                input logic [31:0] data, input logic [1:0] s,
                                input logic ordy, input logic [3:0] exp_rdy);
        vec_t v;
        v.m = m; v.vld = vld; v.lst = lst; v.data = data;
        v.sel = s; v.ordy = ordy; v.exp_rdy = exp_rdy;
        return v;
    endfunction

    // Called at a falling edge: check the presented beat, drive the vector, check in_ready.
    task automatic apply(input vec_t v);
        logic       ov;
        logic [3:0] rdy;
        beat_t      b;
        ov = v.m ? r_out_valid : s_out_valid;
        chk("out_valid", ov, sb.size() != 0);
        if (ov && sb.size() != 0) begin
            b = sb[0];
            chk("out_ch",   v.m ? r_out_ch   : s_out_ch,   b.ch);
            chk("out_data", v.m ? r_out_data : s_out_data, b.data);
            chk("out_last", v.m ? r_out_last : s_out_last, b.last);
        end
        in_valid  = v.vld;
        in_last   = v.lst;
        in_data   = v.data;
        sel       = v.sel;
        out_ready = v.ordy;
        if (out_ready && sb.size() != 0) void'(sb.pop_front());
        #1;
        rdy = v.m ? r_in_ready : s_in_ready;
        chk("in_ready", rdy, v.exp_rdy);
        for (int k = 0; k < 4; k++) begin
            if (v.exp_rdy[k]) begin
                b.ch   = 2'(k);
                b.data = v.data[k*8 +: 8];
                b.last = v.lst[k];
                sb.push_back(b);
            end
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (!at_neg) @(negedge clk);
            at_neg = 1'b0;
            apply(vecs[i]);
        end
    endtask

    task automatic reset_both();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_r_valid", r_out_valid, 0);
        chk("rst_r_data",  r_out_data,  0);
        chk("rst_r_ch",    r_out_ch,    0);
        chk("rst_r_last",  r_out_last,  0);
        chk("rst_r_ready", r_in_ready,  0);
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_data",  s_out_data,  0);
        chk("rst_s_ch",    s_out_ch,    0);
        chk("rst_s_last",  s_out_last,  0);
        chk("rst_s_ready", s_in_ready,  0);
        rst      = 1'b0;
        in_valid = '0;
        sb.delete();
        at_neg = 1'b1;
    endtask

    initial begin
        int a0, b0, c0, d0, e0, f0, f1;
        rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0; sel = '0; out_ready = 1'b1;

        // Round-robin rotation, single-beat packets on every channel
        a0 = vecs.size();
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0001));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0010));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0100));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b1000));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0001));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        0, 1, 4'b0000));
        // ch1 3-beat packet with a stall, others held valid; ch2 follows
        b0 = vecs.size();
        vecs.push_back(mk(1, 4'b0111, 4'b0100, 32'h00C2A0B0, 0, 1, 4'b0010));
        vecs.push_back(mk(1, 4'b0101, 4'b0100, 32'h00C2A0B0, 0, 1, 4'b0000));
        vecs.push_back(mk(1, 4'b0111, 4'b0100, 32'h00C2A1B0, 0, 1, 4'b0010));
        vecs.push_back(mk(1, 4'b0111, 4'b0110, 32'h00C2A2B0, 0, 1, 4'b0010));
        vecs.push_back(mk(1, 4'b0101, 4'b0100, 32'h00C2A2B0, 0, 1, 4'b0100));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        0, 1, 4'b0000));
        // Backpressure: 0x33 held for three cycles, then 0x34
        c0 = vecs.size();
        vecs.push_back(mk(1, 4'b1000, 4'b1000, 32'h33000000, 0, 1, 4'b1000));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, 32'h34000000, 0, 0, 4'b0000));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, 32'h34000000, 0, 0, 4'b0000));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, 32'h34000000, 0, 0, 4'b0000));
        vecs.push_back(mk(1, 4'b1000, 4'b1000, 32'h34000000, 0, 1, 4'b1000));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        0, 1, 4'b0000));
        // sel mode: sel moves mid-packet, then sel points at an idle channel
        d0 = vecs.size();
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h005A000F, 2, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h005B000F, 0, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0101, 4'b0100, 32'h005C000F, 0, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 32'h005C000F, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 32'h00001100, 3, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 32'h00001100, 3, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        0, 1, 4'b0000));
        // Open a ch1 packet, then reset mid-packet; ch0 must win afterwards
        e0 = vecs.size();
        vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h00007700, 0, 1, 4'b0010));
        f0 = vecs.size();
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0001));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 1, 4'b0010));
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        0, 1, 4'b0000));
        f1 = vecs.size();

        reset_both();
        run(a0, d0);
        reset_both();
        run(d0, e0);
        reset_both();
        run(e0, f0);

        @(posedge clk);
        #1;
        chk("pre_rst_valid", r_out_valid, 1);
        rst      = 1'b1;
        in_valid = '1;
        #1;
        chk("async_rst_valid", r_out_valid, 0);
        chk("async_rst_data",  r_out_data,  0);
        chk("async_rst_ready", r_in_ready,  0);
        sb.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = '0;
        at_neg   = 1'b1;
        run(f0, f1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
